load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits between the single-cycle datapath and a multi-cycle data-memory bus.
- Produces the `readData` word consumed by the writeback result selection.
- Turns core load/store requests into one bus transaction, stalling the core until the transaction completes.
- Generates byte enables and replicated write lanes for stores; sign- or zero-extends load data.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles spent in BUS waiting for `busAck` before the transaction is aborted.
- CNT_W, 8: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rstN  in  1  asynchronous, active-low reset.
- memReq  in  1  core requests a load/store this instruction; held high until stall drops.
- memWrite  in  1  1 = store, 0 = load.
- funct3  in  3  RISC-V size/sign field: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr  in  32  byte address.
- writeData  in  32  store data, right-aligned.
- stall  out  1  holds PC and register writes while high.
- readData  out  32  extended load result; registered.
- misaligned  out  1  one-cycle pulse on an illegal or misaligned request.
- busErr  out  1  one-cycle pulse on timeout.
- busReq  out  1  bus request; held until acknowledged.
- busWe  out  1  bus write strobe.
- busAddr  out  32  word-aligned address, {addr[31:2], 2'b00}.
- busWdata  out  32  lane-replicated store data.
- busBe  out  4  byte enables.
- busAck  in  1  one-cycle completion pulse from the bus.
- busRdata  in  32  read word; valid when busAck = 1.

Behaviour:
- Reset is asynchronous: state = IDLE, and busReq, busWe, busBe, busAddr, busWdata, readData, counter, misaligned and busErr are all 0.
- Reset asserted mid-transaction abandons it immediately; no ack is awaited.
- States are IDLE, BUS and DONE.
- Request legality: a request is illegal if funct3 is 011, 110 or 111, or if it is a store with funct3[2] = 1.
- Request alignment: a request is misaligned if H/HU has addr[0] = 1, or W has addr[1:0] ≠ 0.
- IDLE, illegal or misaligned request:
  - stall = 0 and misaligned = 1 (both combinational).
  - No bus activity; readData is unchanged; state stays IDLE.
- IDLE, legal request:
  - stall = 1 combinationally in the same cycle.
  - At the clock edge, register busAddr, busWe, busBe, busWdata, funct3 and addr[1:0]; set busReq = 1; clear the counter; go to BUS.
- BUS:
  - stall = 1 and busReq = 1; all bus outputs are held stable.
  - On busAck: for a load, readData ← extend(busRdata); clear busReq; go to DONE.
  - If no ack arrives and the counter = TIMEOUT_CYCLES: busErr = 1 for one cycle, readData ← 0, clear busReq, go to DONE.
  - Otherwise the counter increments.
- DONE: stall = 0 for exactly one cycle so the core commits; then go to IDLE.
  - memReq still high in DONE is ignored, so the same instruction never relaunches.
- Latency: a request is made at cycle 0 and busAck arrives k cycles after BUS entry; stall falls in cycle k+2. The minimum total is 2 stalled cycles.
- Byte enables:
  - B: 4'b0001 << addr[1:0].
  - H: 4'b0011 << {addr[1], 1'b0}.
  - W: 4'b1111.
- Write data: B replicates writeData[7:0] ×4; H replicates writeData[15:0] ×2; W passes through.
- Load extension:
  - Select the byte or halfword lane from the registered addr[1:0].
  - B and H sign-extend from bit 7 or 15; BU and HU zero-extend; W passes through.
- An ack outside BUS is ignored. readData holds its value across stores and errors, except that a timeout writes 0.

Decomposition:
- Shared package `lsu_pkg`:
  - `lsu_state_t` enum {IDLE, BUS, DONE}.
  - funct3 constants F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU.
- One sub-module, `load_extend`: combinational lane select plus sign/zero extend (inputs: word, offset, funct3). It is reused by verification as the reference model.

Test Plan:
- LW, addr 0x100, busAck 3 cycles after BUS entry, busRdata 0xDEADBEEF → busAddr 0x100, busBe 1111; stall high 4 cycles; readData 0xDEADBEEF in DONE.
- LB, addr 0x103, busRdata 0x80FF_0000 → busBe 1000; readData 0xFFFFFF80. The same access as LBU → readData 0x00000080.
- SH, addr 0x202, writeData 0x1234ABCD → busWe 1, busBe 1100, busWdata 0xABCDABCD, busAddr 0x200; readData unchanged.
- LW, addr 0x101 → misaligned pulse, stall never high, busReq stays 0. funct3 011 → same response.
- No busAck for TIMEOUT_CYCLES = 4 → busErr pulses in the 5th BUS cycle; readData 0; stall drops one cycle later.
- rstN low two cycles into BUS → busReq 0 and readData 0 asynchronously; a late busAck after reset is ignored and the unit sits in IDLE.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared types, funct3 encodings and request decode helpers for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Unsigned forms have no store counterpart, so a store with funct3[2] set is illegal.
  function automatic logic req_illegal(input logic [2:0] f3, input logic we);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (we && f3[2]);
  endfunction

  function automatic logic req_misaligned(input logic [1:0] sz, input logic [1:0] ofs);
    logic bad;
    bad = 1'b0;
    case (sz)
      2'b01:   bad = ofs[0];
      2'b10:   bad = (ofs != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] sz, input logic [1:0] ofs);
    logic [3:0] be;
    be = 4'b1111;
    case (sz)
      2'b00:   be = 4'b0001 << ofs;
      2'b01:   be = 4'b0011 << {ofs[1], 1'b0};
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] lane_data(input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] d;
    d = wd;
    case (sz)
      2'b00:   d = {4{wd[7:0]}};
      2'b01:   d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and the memory subsystem (slave).
interface load_store_unit_if;

  logic        busReq;
  logic        busWe;
  logic [31:0] busAddr;
  logic [31:0] busWdata;
  logic [3:0]  busBe;
  logic        busAck;
  logic [31:0] busRdata;

  modport master (
    output busReq, busWe, busAddr, busWdata, busBe,
    input  busAck, busRdata
  );

  modport slave (
    input  busReq, busWe, busAddr, busWdata, busBe,
    output busAck, busRdata
  );

endinterface

// File: rtl/load_store_unit_load_extend.sv
// Load lane select and sign/zero extension of a bus read word.
module load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_l;
  logic [15:0] half_l;

  always_comb begin
    byte_l = word[{offset, 3'b000} +: 8];
    half_l = offset[1] ? word[31:16] : word[15:0];
    data   = word;
    case (funct3)
      F3_LB:   data = {{24{byte_l[7]}}, byte_l};
      F3_LBU:  data = {24'b0, byte_l};
      F3_LH:   data = {{16{half_l[15]}}, half_l};
      F3_LHU:  data = {16'b0, half_l};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns one core memory request into one multi-cycle bus
// transaction, stalling the core until it completes or times out.
//
//   state | meaning
//   IDLE  | waiting for a core request; bad requests are rejected here
//   BUS   | transaction outstanding, bus outputs frozen, timeout running
//   DONE  | one unstalled cycle so the core commits; request not relaunched
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic        memReq,
  input  logic        memWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] writeData,
  output logic        stall,
  output logic [31:0] readData,
  output logic        misaligned,
  output logic        busErr,
  load_store_unit_if.master bus
);

  lsu_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       f3_q;
  logic [1:0]       ofs_q;
  logic             req_bad;
  logic             launch;
  logic             timeout;
  logic [31:0]      ext_data;

  assign req_bad    = req_illegal(funct3, memWrite) || req_misaligned(funct3[1:0], addr[1:0]);
  assign launch     = (state == IDLE) && memReq && !req_bad;
  assign misaligned = (state == IDLE) && memReq && req_bad;
  assign stall      = launch || (state == BUS);

  // Down-counter is loaded with the budget on BUS entry; reaching zero with no ack aborts.
  assign timeout = (state == BUS) && !bus.busAck && (cnt == '0);
  assign busErr  = timeout;

  load_extend u_load_extend (
    .word   (bus.busRdata),
    .offset (ofs_q),
    .funct3 (f3_q),
    .data   (ext_data)
  );

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state        <= IDLE;
      cnt          <= '0;
      f3_q         <= '0;
      ofs_q        <= '0;
      readData     <= '0;
      bus.busReq   <= 1'b0;
      bus.busWe    <= 1'b0;
      bus.busAddr  <= '0;
      bus.busWdata <= '0;
      bus.busBe    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (launch) begin
            bus.busAddr  <= {addr[31:2], 2'b00};
            bus.busWe    <= memWrite;
            bus.busBe    <= byte_en(funct3[1:0], addr[1:0]);
            bus.busWdata <= lane_data(funct3[1:0], writeData);
            bus.busReq   <= 1'b1;
            f3_q         <= funct3;
            ofs_q        <= addr[1:0];
            cnt          <= CNT_W'(TIMEOUT_CYCLES);
            state        <= BUS;
          end
        end
        BUS: begin
          if (bus.busAck) begin
            if (!bus.busWe) readData <= ext_data;
            bus.busReq <= 1'b0;
            state      <= DONE;
          end else if (cnt == '0) begin
            readData   <= '0;
            bus.busReq <= 1'b0;
            state      <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit (timeout budget shortened to 4 cycles).
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        memReq = 1'b0;
  logic        memWrite = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] writeData = 32'h0;
  wire         stall;
  wire  [31:0] readData;
  wire         misaligned;
  wire         busErr;

  int checks = 0;
  int failures = 0;

  // Observations gathered by run_access
  int          stall_cnt, err_cycle, err_n;
  logic        hung, bus_stable, cap_we, cap_req, done_busreq, post_busreq;
  logic [31:0] cap_addr, cap_wdata, rd_done;
  logic [3:0]  cap_be;

  load_store_unit_if bus ();

  load_store_unit #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
    .clk        (clk),
    .rstN       (rstN),
    .memReq     (memReq),
    .memWrite   (memWrite),
    .funct3     (funct3),
    .addr       (addr),
    .writeData  (writeData),
    .stall      (stall),
    .readData   (readData),
    .misaligned (misaligned),
    .busErr     (busErr),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge; observations are taken 1 ns later.
  task automatic run_access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input int ack_at, input logic [31:0] rdata);
    int n;
    stall_cnt = 0; err_cycle = 0; err_n = 0; hung = 1'b0; bus_stable = 1'b1;
    @(negedge clk);
    memReq = 1'b1; memWrite = we; funct3 = f3; addr = a; writeData = wd;
    bus.busRdata = rdata;
    #1;
    if (stall) stall_cnt++;
    n = 1;
    forever begin
      @(negedge clk);
      bus.busAck = (n == ack_at);
      #1;
      if (!stall) break;
      stall_cnt++;
      if (busErr) begin err_cycle = n; err_n++; end
      if (n == 1) begin
        cap_addr = bus.busAddr; cap_be = bus.busBe; cap_we = bus.busWe;
        cap_wdata = bus.busWdata; cap_req = bus.busReq;
      end else if (bus.busAddr !== cap_addr || bus.busBe !== cap_be || bus.busWe !== cap_we ||
                   bus.busWdata !== cap_wdata || bus.busReq !== 1'b1) begin
        bus_stable = 1'b0;
      end
      if (n >= 20) begin hung = 1'b1; break; end
      n++;
    end
    bus.busAck = 1'b0;
    rd_done = readData;
    done_busreq = bus.busReq;
    @(negedge clk);
    memReq = 1'b0;
    #1;
    post_busreq = bus.busReq;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (bus.busReq !== 1'b0) begin failures++; $display("FAIL rst_busReq got=%b exp=0", bus.busReq); end
    checks++; if (bus.busWe !== 1'b0) begin failures++; $display("FAIL rst_busWe got=%b exp=0", bus.busWe); end
    checks++; if (bus.busBe !== 4'h0) begin failures++; $display("FAIL rst_busBe got=%h exp=0", bus.busBe); end
    checks++; if (bus.busAddr !== 32'h0) begin failures++; $display("FAIL rst_busAddr got=%h exp=0", bus.busAddr); end
    checks++; if (bus.busWdata !== 32'h0) begin failures++; $display("FAIL rst_busWdata got=%h exp=0", bus.busWdata); end
    checks++; if (readData !== 32'h0) begin failures++; $display("FAIL rst_readData got=%h exp=0", readData); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rst_stall got=%b exp=0", stall); end
    checks++; if (misaligned !== 1'b0) begin failures++; $display("FAIL rst_misaligned got=%b exp=0", misaligned); end
    checks++; if (busErr !== 1'b0) begin failures++; $display("FAIL rst_busErr got=%b exp=0", busErr); end
    repeat (2) @(negedge clk);
    rstN = 1'b1;
  endtask

  task automatic test_lw();
    run_access(1'b0, F3_LW, 32'h100, 32'h0, 3, 32'hDEADBEEF);
    checks++; if (hung !== 1'b0) begin failures++; $display("FAIL lw_hung got=%b exp=0", hung); end
    checks++; if (cap_req !== 1'b1) begin failures++; $display("FAIL lw_busReq got=%b exp=1", cap_req); end
    checks++; if (cap_addr !== 32'h100) begin failures++; $display("FAIL lw_busAddr got=%h exp=00000100", cap_addr); end
    checks++; if (cap_be !== 4'b1111) begin failures++; $display("FAIL lw_busBe got=%b exp=1111", cap_be); end
    checks++; if (cap_we !== 1'b0) begin failures++; $display("FAIL lw_busWe got=%b exp=0", cap_we); end
    checks++; if (stall_cnt != 4) begin failures++; $display("FAIL lw_stall_cycles got=%0d exp=4", stall_cnt); end
    checks++; if (bus_stable !== 1'b1) begin failures++; $display("FAIL lw_bus_stable got=%b exp=1", bus_stable); end
    checks++; if (rd_done !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_readData got=%h exp=deadbeef", rd_done); end
    checks++; if (done_busreq !== 1'b0) begin failures++; $display("FAIL lw_done_busReq got=%b exp=0", done_busreq); end
    checks++; if (post_busreq !== 1'b0) begin failures++; $display("FAIL lw_no_relaunch got=%b exp=0", post_busreq); end
  endtask

  task automatic test_lb_lbu();
    run_access(1'b0, F3_LB, 32'h103, 32'h0, 1, 32'h80FF_0000);
    checks++; if (cap_be !== 4'b1000) begin failures++; $display("FAIL lb_busBe got=%b exp=1000", cap_be); end
    checks++; if (cap_addr !== 32'h100) begin failures++; $display("FAIL lb_busAddr got=%h exp=00000100", cap_addr); end
    checks++; if (rd_done !== 32'hFFFFFF80) begin failures++; $display("FAIL lb_readData got=%h exp=ffffff80", rd_done); end
    run_access(1'b0, F3_LBU, 32'h103, 32'h0, 2, 32'h80FF_0000);
    checks++; if (rd_done !== 32'h00000080) begin failures++; $display("FAIL lbu_readData got=%h exp=00000080", rd_done); end
    checks++; if (stall_cnt != 3) begin failures++; $display("FAIL lbu_stall_cycles got=%0d exp=3", stall_cnt); end
  endtask

  task automatic test_store_half();
    run_access(1'b1, 3'b001, 32'h202, 32'h1234ABCD, 2, 32'hFFFF_FFFF);
    checks++; if (cap_we !== 1'b1) begin failures++; $display("FAIL sh_busWe got=%b exp=1", cap_we); end
    checks++; if (cap_be !== 4'b1100) begin failures++; $display("FAIL sh_busBe got=%b exp=1100", cap_be); end
    checks++; if (cap_wdata !== 32'hABCDABCD) begin failures++; $display("FAIL sh_busWdata got=%h exp=abcdabcd", cap_wdata); end
    checks++; if (cap_addr !== 32'h200) begin failures++; $display("FAIL sh_busAddr got=%h exp=00000200", cap_addr); end
    checks++; if (rd_done !== 32'h00000080) begin failures++; $display("FAIL sh_readData_kept got=%h exp=00000080", rd_done); end
    run_access(1'b1, 3'b000, 32'h301, 32'h000000A5, 1, 32'h0);
    checks++; if (cap_be !== 4'b0010) begin failures++; $display("FAIL sb_busBe got=%b exp=0010", cap_be); end
    checks++; if (cap_wdata !== 32'hA5A5A5A5) begin failures++; $display("FAIL sb_busWdata got=%h exp=a5a5a5a5", cap_wdata); end
  endtask

  task automatic test_misaligned();
    logic [2:0]  f3s [4];
    logic [31:0] as  [4];
    logic        wes [4];
    f3s = '{F3_LW, 3'b011, F3_LH, F3_LBU};
    as  = '{32'h101, 32'h100, 32'h203, 32'h100};
    wes = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      memReq = 1'b1; memWrite = wes[i]; funct3 = f3s[i]; addr = as[i];
      #1;
      checks++; if (misaligned !== 1'b1) begin failures++; $display("FAIL bad%0d_misaligned got=%b exp=1", i, misaligned); end
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL bad%0d_stall got=%b exp=0", i, stall); end
      @(negedge clk);
      memReq = 1'b0;
      #1;
      checks++; if (bus.busReq !== 1'b0) begin failures++; $display("FAIL bad%0d_busReq got=%b exp=0", i, bus.busReq); end
      checks++; if (readData !== 32'h80) begin failures++; $display("FAIL bad%0d_readData got=%h exp=00000080", i, readData); end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    memReq = 1'b1; memWrite = 1'b0; funct3 = F3_LW; addr = 32'h300;
    bus.busRdata = 32'h5555_5555;
    repeat (2) @(negedge clk);
    #2;
    checks++; if (bus.busReq !== 1'b1) begin failures++; $display("FAIL ar_busReq_before got=%b exp=1", bus.busReq); end
    checks++; if (readData !== 32'h80) begin failures++; $display("FAIL ar_readData_before got=%h exp=00000080", readData); end
    rstN = 1'b0; memReq = 1'b0;
    #1;
    checks++; if (bus.busReq !== 1'b0) begin failures++; $display("FAIL ar_busReq got=%b exp=0", bus.busReq); end
    checks++; if (readData !== 32'h0) begin failures++; $display("FAIL ar_readData got=%h exp=0", readData); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL ar_stall got=%b exp=0", stall); end
    @(negedge clk);
    rstN = 1'b1; bus.busAck = 1'b1;
    @(negedge clk);
    bus.busAck = 1'b0;
    #1;
    checks++; if (bus.busReq !== 1'b0) begin failures++; $display("FAIL ar_late_ack_busReq got=%b exp=0", bus.busReq); end
    checks++; if (readData !== 32'h0) begin failures++; $display("FAIL ar_late_ack_readData got=%h exp=0", readData); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL ar_late_ack_stall got=%b exp=0", stall); end
  endtask

  task automatic test_timeout();
    run_access(1'b0, F3_LW, 32'h108, 32'h0, 2, 32'h13579BDF);
    checks++; if (rd_done !== 32'h13579BDF) begin failures++; $display("FAIL to_pre_readData got=%h exp=13579bdf", rd_done); end
    run_access(1'b0, F3_LW, 32'h10C, 32'h0, 0, 32'hCAFEF00D);
    checks++; if (hung !== 1'b0) begin failures++; $display("FAIL to_hung got=%b exp=0", hung); end
    checks++; if (err_cycle != 5) begin failures++; $display("FAIL to_busErr_cycle got=%0d exp=5", err_cycle); end
    checks++; if (err_n != 1) begin failures++; $display("FAIL to_busErr_pulses got=%0d exp=1", err_n); end
    checks++; if (stall_cnt != 6) begin failures++; $display("FAIL to_stall_cycles got=%0d exp=6", stall_cnt); end
    checks++; if (rd_done !== 32'h0) begin failures++; $display("FAIL to_readData got=%h exp=0", rd_done); end
    checks++; if (done_busreq !== 1'b0) begin failures++; $display("FAIL to_busReq got=%b exp=0", done_busreq); end
  endtask

  task automatic test_min_latency();
    run_access(1'b0, F3_LH, 32'h002, 32'h0, 1, 32'h8001_7FFF);
    checks++; if (stall_cnt != 2) begin failures++; $display("FAIL lh_stall_cycles got=%0d exp=2", stall_cnt); end
    checks++; if (cap_be !== 4'b1100) begin failures++; $display("FAIL lh_busBe got=%b exp=1100", cap_be); end
    checks++; if (rd_done !== 32'hFFFF8001) begin failures++; $display("FAIL lh_readData got=%h exp=ffff8001", rd_done); end
    run_access(1'b0, F3_LHU, 32'h000, 32'h0, 1, 32'h0000_F00D);
    checks++; if (cap_be !== 4'b0011) begin failures++; $display("FAIL lhu_busBe got=%b exp=0011", cap_be); end
    checks++; if (rd_done !== 32'h0000F00D) begin failures++; $display("FAIL lhu_readData got=%h exp=0000f00d", rd_done); end
  endtask

  initial begin
    bus.busAck = 1'b0;
    bus.busRdata = 32'h0;
    test_reset();
    test_lw();
    test_lb_lbu();
    test_store_half();
    test_misaligned();
    test_async_reset();
    test_timeout();
    test_min_latency();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
